scatterer: RTL
==============

Name: scatterer

Overview:
- Charge-deposition counterpart of the grid interpolator: takes one particle per cycle (position plus quantity) and adds bilinearly weighted shares of the quantity into the four surrounding grid cells.
- Performs a pipelined read-modify-write on four grid BRAM banks. Bank k holds corner k: k[0] selects the x offset, k[1] the y offset.
- Sits between the particle pusher and the grid accumulation memory used by the field solver.
- Stalls input while a new particle's cells overlap any still-pending update.

Parameters:
- DWIDTH, 16, width of the unsigned deposited quantity.
- ACCWIDTH, 48, width of a grid accumulator word. Format is unsigned fixed point with PFRAC*2 fractional bits. Must be at least DWIDTH+PFRAC*2.
- RD_LAT, 2, BRAM read latency in cycles, counted from the raddr_out register to valid rdata_in.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid  in  1  input particle valid
- ready_out  out  1  particle accepted when valid && ready_out
- pos  in  posvec_t  particle position (whole and fraction fields per axis)
- q_in  in  DWIDTH  quantity to deposit
- busy_out  out  1  high while any accepted particle has not yet issued its write
- raddr_out  out  addr_t[3:0]  per-bank read address
- rdata_in  in  [3:0][ACCWIDTH]  per-bank read data
- wen_out  out  1  write enable, common to all four banks
- waddr_out  out  addr_t[3:0]  per-bank write address
- wdata_out  out  [3:0][ACCWIDTH]  per-bank write data

Behaviour:
- Reset (rst=1 at an edge): raddr_out, waddr_out, wdata_out, wen_out and busy_out all go to 0.
- Reset clears every pipeline stage and every in-flight tag. Updates that have not yet been written are dropped and do not reach memory.
- ready_out is 0 while rst is high and becomes 1 on the first cycle after reset.
- Accept happens at cycle T when valid && ready_out.
  - At T+1: raddr_out[k].x = pos.x.whole + k[0] and raddr_out[k].y = pos.y.whole + k[1]. Addition wraps at the addr_t field width, giving a periodic grid.
  - raddr_out holds its value when nothing is accepted.
- Weights are 2*PFRAC+1 bits wide, with fx and fy the fraction fields and F = 2^PFRAC:
  - w0 = (F-fx)(F-fy)
  - w1 = fx(F-fy)
  - w2 = (F-fx)fy
  - w3 = fx·fy
  - The weights sum exactly to 2^(2*PFRAC). A zero fraction gives a full weight of F with no overflow.
- Contribution c_k = q_in * w_k. This is exact and fits in DWIDTH+2*PFRAC bits.
- Write happens at T+1+RD_LAT+2, i.e. at T+5 with defaults.
  - wen_out=1 for exactly one cycle.
  - waddr_out = the T+1 raddr_out values.
  - wdata_out[k] = rdata_in[k] (captured at T+1+RD_LAT) + c_k, modulo 2^ACCWIDTH.
- Throughput is one particle per cycle when there are no hazards. Write order equals accept order.
- Hazard rule: each accepted particle holds a tag (x0, y0) from acceptance until the cycle its wen_out is high, inclusive.
  - ready_out = 0 combinationally when valid is high and some tag satisfies (pos.x.whole - x0) mod 2^XW in {-1, 0, 1} and the same holds for y.
  - This guarantees a read never precedes a pending write to the same cell.
- ready_out = 1 when valid is low. valid may be held while ready_out = 0, and pos and q_in must stay stable while it is.
- busy_out = 1 exactly while at least one tag is live.
- Neither an empty nor a full pipeline is a special case: the pipeline depth bounds live tags at RD_LAT+3.

Test Plan:
- Reset, then one particle with pos whole (5,7), fractions (0,0), q=100 and all memory 0 -> raddr_out at T+1 = bank0 (5,7), bank1 (6,7), bank2 (5,8), bank3 (6,8). At T+5: wen_out=1, wdata_out = {100<<24, 0, 0, 0}.
- Same cell with fractions (0x800, 0x800), q=4 and memory preloaded to 1 -> each wdata_out = 1 + (1<<24).
- Back-to-back same cell, q=10 then q=20, fractions 0 -> second accept is stalled until the first write cycle has passed. bank0 ends at 30<<24. ready_out is low for exactly 5 cycles.
- Cells (0,0), (4,0), (8,0), (12,0) on consecutive cycles -> no stall, four writes on consecutive cycles in order, busy_out drops the cycle after the last write.
- Position whole at (max,max) -> bank1 x, bank2 y and bank3 both coordinates wrap to 0. An immediately following particle at (0,0) stalls because of the wrap adjacency.
- Assert rst two cycles after an accept -> no wen_out ever asserts for that particle. All outputs are 0 and ready_out=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/scatterer.sv
// scatterer: bilinear charge deposition onto a four-bank grid accumulator.
// Takes one particle per cycle (position + quantity), reads the four
// surrounding grid cells, adds the weighted shares of the quantity and
// writes them back. A tag scoreboard stalls any particle whose cells are
// adjacent to a still-pending update, so reads never overtake writes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid, ready_out    particle handshake (accept on valid && ready_out)
//   pos, q_in           particle position and quantity
//   busy_out            high while any accepted particle has not written
//   raddr_out/rdata_in  per-bank read address / read data (RD_LAT cycles)
//   wen_out             common write enable
//   waddr_out/wdata_out per-bank write address / write data

package scatterer_pkg;
    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 8;
    localparam int unsigned PFRAC = 12;

    typedef struct packed {
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } addr_t;

    typedef struct packed {
        logic [XW-1:0]    whole;
        logic [PFRAC-1:0] frac;
    } xcoord_t;

    typedef struct packed {
        logic [YW-1:0]    whole;
        logic [PFRAC-1:0] frac;
    } ycoord_t;

    typedef struct packed {
        ycoord_t y;
        xcoord_t x;
    } posvec_t;
endpackage

module scatterer
    import scatterer_pkg::*;
#(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned ACCWIDTH = 48,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    output logic                     ready_out,
    input  posvec_t                  pos,
    input  logic [DWIDTH-1:0]        q_in,
    output logic                     busy_out,
    output addr_t [3:0]              raddr_out,
    input  logic [3:0][ACCWIDTH-1:0] rdata_in,
    output logic                     wen_out,
    output addr_t [3:0]              waddr_out,
    output logic [3:0][ACCWIDTH-1:0] wdata_out
);

    // Stage d holds a particle d cycles after acceptance. Stage 1 is the
    // raddr_out register itself; read data is valid during stage NST-1 and
    // captured into stage NST; the write register follows stage NST.
    localparam int unsigned NST = RD_LAT + 2;
    localparam int unsigned WW  = 2*PFRAC + 1;
    localparam int unsigned PW  = 2*PFRAC + 2;
    localparam int unsigned CW  = DWIDTH + 2*PFRAC;
    localparam logic [PFRAC:0] F = (PFRAC+1)'(1) << PFRAC;

    logic [NST:1]               v_q;
    addr_t [3:0]                ra_q  [2:NST];
    logic  [3:0][CW-1:0]        c_q   [2:NST];
    logic  [3:0][WW-1:0]        w1_q;
    logic  [DWIDTH-1:0]         q1_q;
    logic  [3:0][ACCWIDTH-1:0]  cap_q;

    logic                       accept;
    logic                       hazard;
    logic  [PFRAC:0]            fxc, fyc, fxp, fyp;
    logic  [3:0][WW-1:0]        w_in;
    logic  [3:0][CW-1:0]        c1;

    // Cyclic adjacency: difference of -1, 0 or +1 on both axes.
    function automatic logic near(input addr_t t, input posvec_t p);
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        dx = p.x.whole - t.x;
        dy = p.y.whole - t.y;
        return ((dx == '0) || (dx == XW'(1)) || (dx == '1)) &&
               ((dy == '0) || (dy == YW'(1)) || (dy == '1));
    endfunction

    always_comb begin
        hazard = v_q[1] && near(raddr_out[0], pos);
        for (int unsigned d = 2; d <= NST; d++) begin
            if (v_q[d] && near(ra_q[d][0], pos)) hazard = 1'b1;
        end
        if (wen_out && near(waddr_out[0], pos)) hazard = 1'b1;
        ready_out = !rst && !(valid && hazard);
        accept    = valid && ready_out;
        busy_out  = (|v_q) || wen_out;
    end

    // Weights use F-f (PFRAC+1 bits) so a zero fraction yields exactly F.
    always_comb begin
        logic [PW-1:0] p0, p1, p2, p3;
        fxp = {1'b0, pos.x.frac};
        fyp = {1'b0, pos.y.frac};
        fxc = F - fxp;
        fyc = F - fyp;
        p0  = PW'(fxc) * PW'(fyc);
        p1  = PW'(fxp) * PW'(fyc);
        p2  = PW'(fxc) * PW'(fyp);
        p3  = PW'(fxp) * PW'(fyp);
        w_in[0] = p0[WW-1:0];
        w_in[1] = p1[WW-1:0];
        w_in[2] = p2[WW-1:0];
        w_in[3] = p3[WW-1:0];
        for (int unsigned k = 0; k < 4; k++) begin
            c1[k] = CW'(q1_q) * CW'(w1_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            raddr_out <= '0;
            waddr_out <= '0;
            wdata_out <= '0;
            wen_out   <= 1'b0;
            w1_q      <= '0;
            q1_q      <= '0;
            cap_q     <= '0;
            for (int unsigned d = 2; d <= NST; d++) begin
                ra_q[d] <= '0;
                c_q[d]  <= '0;
            end
        end else begin
            if (accept) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    raddr_out[k].x <= pos.x.whole + XW'(k % 2);
                    raddr_out[k].y <= pos.y.whole + YW'(k / 2);
                end
                w1_q <= w_in;
                q1_q <= q_in;
            end
            v_q[1] <= accept;
            for (int unsigned d = 2; d <= NST; d++) begin
                v_q[d] <= v_q[d-1];
            end
            ra_q[2] <= raddr_out;
            c_q[2]  <= c1;
            for (int unsigned d = 3; d <= NST; d++) begin
                ra_q[d] <= ra_q[d-1];
                c_q[d]  <= c_q[d-1];
            end
            cap_q   <= rdata_in;
            wen_out <= v_q[NST];
            if (v_q[NST]) begin
                waddr_out <= ra_q[NST];
                for (int unsigned k = 0; k < 4; k++) begin
                    wdata_out[k] <= cap_q[k] + ACCWIDTH'(c_q[NST][k]);
                end
            end
        end
    end

endmodule
